// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - BIST sequencer: LFSR seed, capture/shift patterns, flush, MISR signature compare
module bist_sequencer #(
    parameter int                SCAN_LEN        = 8,
    parameter int                NUM_PATTERNS    = 16,
    parameter int                SIG_W           = 6,
    parameter logic [SIG_W-1:0]  SIGNATURE_VALID = 6'b101010
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [SIG_W-1:0]                        signature,
    output logic                                    running,
    output logic                                    scan_en,
    output logic                                    seed_load,
    output logic                                    misr_clr,
    output logic                                    bist_end,
    output logic                                    pass_fail,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]       pattern_cnt
);

    localparam int PW = $clog2(NUM_PATTERNS + 1);
    localparam int SW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam logic [SW-1:0] SHIFT_LAST = SW'(SCAN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        CAPTURE,
        SHIFT,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    state_t        state;
    logic [SW-1:0] shift_cnt;
    logic          start_q;
    logic          start_armed;
    logic          start_edge;

    // start_armed keeps a level held high across reset release from launching a run
    assign start_edge = start & ~start_q & start_armed;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            shift_cnt   <= '0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            running     <= 1'b0;
            scan_en     <= 1'b0;
            seed_load   <= 1'b0;
            misr_clr    <= 1'b0;
            bist_end    <= 1'b0;
            pass_fail   <= 1'b0;
            pattern_cnt <= '0;
        end else begin
            start_q   <= start;
            seed_load <= 1'b0;
            misr_clr  <= 1'b0;
            if (!start) begin
                start_armed <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state       <= SEED;
                        seed_load   <= 1'b1;
                        misr_clr    <= 1'b1;
                        running     <= 1'b1;
                        scan_en     <= 1'b0;
                        bist_end    <= 1'b0;
                        pass_fail   <= 1'b0;
                        pattern_cnt <= '0;
                        shift_cnt   <= '0;
                    end
                end
                SEED: begin
                    state   <= CAPTURE;
                    scan_en <= 1'b0;
                end
                CAPTURE: begin
                    state     <= SHIFT;
                    scan_en   <= 1'b1;
                    shift_cnt <= '0;
                end
                SHIFT: begin
                    if (shift_cnt == SHIFT_LAST) begin
                        shift_cnt   <= '0;
                        pattern_cnt <= pattern_cnt + 1'b1;
                        if (pattern_cnt == PAT_LAST) begin
                            state <= FLUSH;
                        end else begin
                            state   <= CAPTURE;
                            scan_en <= 1'b0;
                        end
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (shift_cnt == SHIFT_LAST) begin
                        shift_cnt <= '0;
                        state     <= COMPARE;
                        scan_en   <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                COMPARE: begin
                    state     <= DONE;
                    pass_fail <= (signature == SIGNATURE_VALID);
                    bist_end  <= 1'b1;
                    running   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    scan_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
